dataregister_bank: RTL and testbench
====================================

# dataregister_bank

Parametrised bank of `DEPTH` data registers, each `DATAWIDTH` bits wide. It has one active-low write port with four per-access modes (load, shift, increment, clear), per-entry valid flags, a carry/shift-out flag, and two registered read ports with write-through. It sits between datapath producers and consumers as general-purpose operand and accumulator storage, replacing individual single-word data registers.

## Interface
- `DATAWIDTH`, default 8: width of each entry and of the data ports.
- `ADDRWIDTH`, default 2: address width; `DEPTH` = 2**`ADDRWIDTH` entries. Must be at least 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `lowWr`  in  1  active-low write strobe; 0 = perform the `Mode` operation on `WrAddr` this edge.
- `Mode`  in  2  00 LOAD, 01 SHIFT, 10 INC, 11 CLEAR.
- `WrAddr`  in  ADDRWIDTH  target entry of the write operation.
- `DataIn`  in  DATAWIDTH  LOAD data; bit 0 is the serial input for SHIFT.
- `RdAddrA`  in  ADDRWIDTH  read address, port A.
- `RdAddrB`  in  ADDRWIDTH  read address, port B.
- `DataOutA`  out  DATAWIDTH  registered read data, port A.
- `DataOutB`  out  DATAWIDTH  registered read data, port B.
- `Valid`  out  DEPTH  bit i = 1 when entry i holds written data; direct from state.
- `Carry`  out  1  registered overflow / shift-out flag of the last write operation.

## Operation
- Storage: `DEPTH` entries `R[i]`, one valid bit `V[i]` per entry, plus the `Carry` register.
- When `lowWr`=1, all entries, `V` and `Carry` hold.
- When `lowWr`=0, only entry `k`=`WrAddr` is affected:
  - LOAD: `R[k]` <= `DataIn`; `V[k]` <= 1; `Carry` <= 0.
  - SHIFT: `R[k]` <= {`R[k]`[DATAWIDTH-2:0], `DataIn`[0]}; `Carry` <= old `R[k]`[DATAWIDTH-1]; `V[k]` <= 1.
  - INC: `R[k]` <= (`R[k]` + 1) mod 2**DATAWIDTH; `Carry` <= 1 iff old `R[k]` was all ones (the value wraps to 0); `V[k]` <= 1.
  - CLEAR: `R[k]` <= 0; `V[k]` <= 0; `Carry` <= 0.
- SHIFT and INC operate on an entry whether or not it is valid. An invalid entry always reads as its stored value, which is 0 after reset or CLEAR.
- Read ports: every edge, `DataOutA` <= next-state value of `R[RdAddrA]`, and likewise for port B. A read of the entry being written in the same cycle therefore returns the post-operation value (write-through).
- Both ports may address the same entry, and either may equal `WrAddr`; both then return identical data.
- Reset (`rst`=1, any time, including mid-operation): all `R`, `V`, `DataOutA`, `DataOutB` and `Carry` go to 0 immediately, without waiting for a clock edge. A write coinciding with reset is discarded. The first operation after release is honoured on the first rising edge with `rst`=0.

## Timing
- Write latency: the operation presented at edge N is visible in `R`/`V` after edge N; `Valid` changes right after edge N.
- Read latency: 1 cycle. An address presented before edge N gives data on `DataOut*` after edge N, reflecting any write at edge N.
- `Carry` updates at the same edge as the write that produces it and holds until the next `lowWr`=0 edge.
- One write per cycle; back-to-back writes to the same entry chain, each using the result of the previous edge.
- All inputs are synchronous to `clk`, except `rst`.
- Outputs are glitch-free registers, except `Valid`, which is a direct register view and equally clean.

## Test plan
- Reset then idle: assert `rst` mid-cycle with nonzero state -> all outputs 0 at once; `Valid`=0000 until the first write.
- LOAD 0xA5 to entry 2 with `RdAddrA`=2 in the same cycle -> `DataOutA`=0xA5 one edge later; `Valid`=0100; `Carry`=0.
- INC entry 1 from 0xFE twice -> values 0xFF then 0x00; `Carry` 0 then 1; `Carry` holds 1 while `lowWr`=1.
- SHIFT entry 0 holding 0x81 with `DataIn`[0]=1 -> 0x03, `Carry`=1; shift again with `DataIn`[0]=0 -> 0x06, `Carry`=0.
- CLEAR entry 2 while port B reads 2 and port A reads 1 -> `DataOutB`=0x00, `Valid`[2]=0, port A unaffected.
- Assert `rst` in the same cycle as a LOAD to entry 3 -> entry 3 stays 0 and `Valid`[3]=0; a LOAD after release succeeds.

Source files
------------

// File: rtl/dataregister_bank.sv
// dataregister_bank: DEPTH x DATAWIDTH register bank with one active-low write port
// (load/shift/increment/clear), per-entry valid flags, carry flag and two write-through read ports.
`default_nettype none

module dataregister_bank #(
   parameter int DATAWIDTH = 8,
   parameter int ADDRWIDTH = 2,
   localparam int DEPTH = 2 ** ADDRWIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 lowWr,
   input  logic [1:0]           Mode,
   input  logic [ADDRWIDTH-1:0] WrAddr,
   input  logic [DATAWIDTH-1:0] DataIn,
   input  logic [ADDRWIDTH-1:0] RdAddrA,
   input  logic [ADDRWIDTH-1:0] RdAddrB,
   output logic [DATAWIDTH-1:0] DataOutA,
   output logic [DATAWIDTH-1:0] DataOutB,
   output logic [DEPTH-1:0]     Valid,
   output logic                 Carry
);

   localparam logic [1:0] MODE_LOAD  = 2'b00;
   localparam logic [1:0] MODE_SHIFT = 2'b01;
   localparam logic [1:0] MODE_INC   = 2'b10;
   localparam logic [1:0] MODE_CLEAR = 2'b11;

   logic [DEPTH-1:0][DATAWIDTH-1:0] regs_q, regs_d;
   logic [DEPTH-1:0]                valid_q, valid_d;
   logic                            carry_q, carry_d;
   logic [DATAWIDTH-1:0]            douta_q, douta_d;
   logic [DATAWIDTH-1:0]            doutb_q, doutb_d;

   logic [DATAWIDTH-1:0] cur_val;
   logic [DATAWIDTH-1:0] shift_val;
   logic [DATAWIDTH-1:0] inc_val;

   assign cur_val = regs_q[WrAddr];
   assign inc_val = cur_val + DATAWIDTH'(1);

   // A one-bit entry has no retained bits; the shift simply replaces it.
   generate
      if (DATAWIDTH == 1) begin : g_shift_narrow
         assign shift_val = DataIn[0];
      end else begin : g_shift_wide
         assign shift_val = {cur_val[DATAWIDTH-2:0], DataIn[0]};
      end
   endgenerate

   always_comb begin
      regs_d  = regs_q;
      valid_d = valid_q;
      carry_d = carry_q;
      if (!lowWr) begin
         case (Mode)
            MODE_LOAD: begin
               regs_d[WrAddr]  = DataIn;
               valid_d[WrAddr] = 1'b1;
               carry_d         = 1'b0;
            end
            MODE_SHIFT: begin
               regs_d[WrAddr]  = shift_val;
               valid_d[WrAddr] = 1'b1;
               carry_d         = cur_val[DATAWIDTH-1];
            end
            MODE_INC: begin
               regs_d[WrAddr]  = inc_val;
               valid_d[WrAddr] = 1'b1;
               carry_d         = &cur_val;
            end
            default: begin
               regs_d[WrAddr]  = '0;
               valid_d[WrAddr] = 1'b0;
               carry_d         = 1'b0;
            end
         endcase
      end
   end

   // Reading the next-state array gives write-through on an address collision.
   always_comb begin
      douta_d = regs_d[RdAddrA];
      doutb_d = regs_d[RdAddrB];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q  <= '0;
         valid_q <= '0;
         carry_q <= 1'b0;
         douta_q <= '0;
         doutb_q <= '0;
      end else begin
         regs_q  <= regs_d;
         valid_q <= valid_d;
         carry_q <= carry_d;
         douta_q <= douta_d;
         doutb_q <= doutb_d;
      end
   end

   assign DataOutA = douta_q;
   assign DataOutB = doutb_q;
   assign Valid    = valid_q;
   assign Carry    = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_dataregister_bank.sv
// tb_dataregister_bank: directed vector table, reset corner cases and random
// traffic checked against an arithmetic model of the register bank.
`default_nettype none

module tb_dataregister_bank;

   logic       clk;
   logic       rst;
   logic       lowWr;
   logic [1:0] Mode;
   logic [1:0] WrAddr;
   logic [7:0] DataIn;
   logic [1:0] RdAddrA;
   logic [1:0] RdAddrB;
   logic [7:0] DataOutA;
   logic [7:0] DataOutB;
   logic [3:0] Valid;
   logic       Carry;

   int checks = 0;
   int errors = 0;

   // Behavioural model: plain integers and flags per entry.
   int m_r [4];
   bit m_v [4];
   bit m_c;
   int m_a;
   int m_b;

   dataregister_bank #(.DATAWIDTH(8), .ADDRWIDTH(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .lowWr    (lowWr),
      .Mode     (Mode),
      .WrAddr   (WrAddr),
      .DataIn   (DataIn),
      .RdAddrA  (RdAddrA),
      .RdAddrB  (RdAddrB),
      .DataOutA (DataOutA),
      .DataOutB (DataOutB),
      .Valid    (Valid),
      .Carry    (Carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       lw;
      bit [1:0] mode;
      bit [1:0] wa;
      bit [7:0] din;
      bit [1:0] ra;
      bit [1:0] rb;
      bit [7:0] exp_a;
      bit [7:0] exp_b;
      bit [3:0] exp_v;
      bit       exp_c;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_r[i] = 0;
         m_v[i] = 1'b0;
      end
      m_c = 1'b0;
      m_a = 0;
      m_b = 0;
   endtask

   function automatic int model_valid();
      int v = 0;
      for (int i = 0; i < 4; i++) if (m_v[i]) v += (1 << i);
      return v;
   endfunction

   task automatic model_step(input bit lw, input int mode, input int k, input int din,
                             input int ra, input int rb);
      if (!lw) begin
         case (mode)
            0: begin m_r[k] = din; m_v[k] = 1'b1; m_c = 1'b0; end
            1: begin
               m_c = (m_r[k] >= 128);
               m_r[k] = ((m_r[k] * 2) % 256) + (din % 2);
               m_v[k] = 1'b1;
            end
            2: begin
               m_c = (m_r[k] == 255);
               m_r[k] = (m_r[k] + 1) % 256;
               m_v[k] = 1'b1;
            end
            default: begin m_r[k] = 0; m_v[k] = 1'b0; m_c = 1'b0; end
         endcase
      end
      m_a = m_r[ra];
      m_b = m_r[rb];
   endtask

   // Called at a negedge; returns at the following negedge with outputs settled.
   task automatic do_cycle(input bit lw, input bit [1:0] mode, input bit [1:0] wa,
                           input bit [7:0] din, input bit [1:0] ra, input bit [1:0] rb);
      lowWr   = lw;
      Mode    = mode;
      WrAddr  = wa;
      DataIn  = din;
      RdAddrA = ra;
      RdAddrB = rb;
      @(posedge clk);
      model_step(lw, int'(mode), int'(wa), int'(din), int'(ra), int'(rb));
      @(negedge clk);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".DataOutA"}, int'(DataOutA), m_a);
      chk({tag, ".DataOutB"}, int'(DataOutB), m_b);
      chk({tag, ".Valid"},    int'(Valid),    model_valid());
      chk({tag, ".Carry"},    int'(Carry),    int'(m_c));
   endtask

   vec_t vecs [12];

   initial begin
      vecs[0]  = '{1'b0, 2'd0, 2'd2, 8'hA5, 2'd2, 2'd0, 8'hA5, 8'h00, 4'b0100, 1'b0};
      vecs[1]  = '{1'b0, 2'd0, 2'd1, 8'hFE, 2'd1, 2'd2, 8'hFE, 8'hA5, 4'b0110, 1'b0};
      vecs[2]  = '{1'b0, 2'd2, 2'd1, 8'h00, 2'd1, 2'd1, 8'hFF, 8'hFF, 4'b0110, 1'b0};
      vecs[3]  = '{1'b0, 2'd2, 2'd1, 8'h00, 2'd1, 2'd1, 8'h00, 8'h00, 4'b0110, 1'b1};
      vecs[4]  = '{1'b1, 2'd0, 2'd1, 8'h77, 2'd1, 2'd2, 8'h00, 8'hA5, 4'b0110, 1'b1};
      vecs[5]  = '{1'b0, 2'd0, 2'd0, 8'h81, 2'd0, 2'd1, 8'h81, 8'h00, 4'b0111, 1'b0};
      vecs[6]  = '{1'b0, 2'd1, 2'd0, 8'h01, 2'd0, 2'd1, 8'h03, 8'h00, 4'b0111, 1'b1};
      vecs[7]  = '{1'b0, 2'd1, 2'd0, 8'hFE, 2'd0, 2'd1, 8'h06, 8'h00, 4'b0111, 1'b0};
      vecs[8]  = '{1'b0, 2'd3, 2'd2, 8'h00, 2'd0, 2'd2, 8'h06, 8'h00, 4'b0011, 1'b0};
      vecs[9]  = '{1'b0, 2'd2, 2'd3, 8'h00, 2'd3, 2'd2, 8'h01, 8'h00, 4'b1011, 1'b0};
      vecs[10] = '{1'b0, 2'd1, 2'd2, 8'h01, 2'd2, 2'd3, 8'h01, 8'h01, 4'b1111, 1'b0};
      vecs[11] = '{1'b1, 2'd0, 2'd0, 8'hFF, 2'd0, 2'd2, 8'h06, 8'h01, 4'b1111, 1'b0};

      rst = 1'b1; lowWr = 1'b1; Mode = 2'd0; WrAddr = 2'd0; DataIn = 8'h00;
      RdAddrA = 2'd0; RdAddrB = 2'd0;
      model_reset();
      @(negedge clk);
      chk("reset.DataOutA", int'(DataOutA), 0);
      chk("reset.Valid",    int'(Valid),    0);
      chk("reset.Carry",    int'(Carry),    0);
      rst = 1'b0;
      do_cycle(1'b1, 2'd0, 2'd0, 8'h00, 2'd0, 2'd0);
      chk("idle.Valid", int'(Valid), 0);

      for (int i = 0; i < 12; i++) begin
         do_cycle(vecs[i].lw, vecs[i].mode, vecs[i].wa, vecs[i].din, vecs[i].ra, vecs[i].rb);
         chk($sformatf("vec%0d.DataOutA", i), int'(DataOutA), int'(vecs[i].exp_a));
         chk($sformatf("vec%0d.DataOutB", i), int'(DataOutB), int'(vecs[i].exp_b));
         chk($sformatf("vec%0d.Valid", i),    int'(Valid),    int'(vecs[i].exp_v));
         chk($sformatf("vec%0d.Carry", i),    int'(Carry),    int'(vecs[i].exp_c));
      end

      // Asynchronous reset mid-cycle with nonzero state, set up so Carry=1.
      do_cycle(1'b0, 2'd1, 2'd0, 8'h00, 2'd0, 2'd2);
      do_cycle(1'b0, 2'd0, 2'd1, 8'hFF, 2'd1, 2'd0);
      do_cycle(1'b0, 2'd2, 2'd1, 8'h00, 2'd1, 2'd0);
      chk("prerst.Carry", int'(Carry), 1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("async.DataOutA", int'(DataOutA), 0);
      chk("async.DataOutB", int'(DataOutB), 0);
      chk("async.Valid",    int'(Valid),    0);
      chk("async.Carry",    int'(Carry),    0);

      // Write coinciding with reset is discarded.
      @(negedge clk);
      lowWr = 1'b0; Mode = 2'd0; WrAddr = 2'd3; DataIn = 8'h5A;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      do_cycle(1'b1, 2'd0, 2'd3, 8'h5A, 2'd3, 2'd3);
      chk_model("rstwr");
      do_cycle(1'b0, 2'd0, 2'd3, 8'h5A, 2'd3, 2'd0);
      chk_model("postrst");
      chk("postrst.lit", int'(DataOutA), 8'h5A);

      for (int n = 0; n < 400; n++) begin
         do_cycle(($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 8'($urandom),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         chk_model($sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
